// File: rtl/rsa_cmd_responder.sv
// rsa_cmd_responder: FPGA-side responder for the ARM command/data protocol.
// Decodes 32-bit commands, captures 1024-bit operands into holding registers,
// launches the exponentiation / Montgomery core, returns the result and
// closes every command with the done / done_read handshake.
// Optional build macro: CMD_TIMEOUT_EN adds a COMPUTE watchdog that aborts
// after TIMEOUT_CYCLES cycles without core_done (flags err_q, keeps res_q).
module rsa_cmd_responder #(
    parameter int DATA_W         = 1024,
    parameter int RES_W          = 512,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [31:0]       arm_to_fpga_cmd,
    input  logic              arm_to_fpga_cmd_valid,
    output logic              fpga_to_arm_done,
    input  logic              fpga_to_arm_done_read,
    input  logic              arm_to_fpga_data_valid,
    output logic              arm_to_fpga_data_ready,
    input  logic [DATA_W-1:0] arm_to_fpga_data,
    output logic              fpga_to_arm_data_valid,
    input  logic              fpga_to_arm_data_ready,
    output logic [DATA_W-1:0] fpga_to_arm_data,
    output logic              core_start,
    output logic              core_mode,
    input  logic              core_done,
    input  logic [RES_W-1:0]  core_result,
    output logic [DATA_W-1:0] mod_q,
    output logic [DATA_W-1:0] rsq_q,
    output logic [DATA_W-1:0] exp_q,
    output logic [3:0]        leds
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RX      = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_TX      = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t            state_r, state_s;
    logic [2:0]        code_r;
    logic              err_r;
    logic [RES_W-1:0]  res_r;
    logic              ready_r, valid_r, done_r, start_r, mode_r;

    logic              latch_s, start_s, err_set_s, err_clr_s, rx_load_s, res_load_s;

`ifdef CMD_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0]       wdog_r;
`endif

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        state_s    = state_r;
        latch_s    = 1'b0;
        start_s    = 1'b0;
        err_set_s  = 1'b0;
        err_clr_s  = 1'b0;
        rx_load_s  = 1'b0;
        res_load_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (arm_to_fpga_cmd_valid) begin
                    latch_s = 1'b1;
                    if (arm_to_fpga_cmd <= 32'd1) begin
                        state_s   = ST_COMPUTE;
                        start_s   = 1'b1;
                        err_clr_s = 1'b1;
                    end else if (arm_to_fpga_cmd <= 32'd4) begin
                        state_s   = ST_RX;
                        err_clr_s = 1'b1;
                    end else if (arm_to_fpga_cmd == 32'd5) begin
                        state_s   = ST_TX;
                        err_clr_s = 1'b1;
                    end else begin
                        state_s   = ST_DONE;
                        err_set_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RX: begin
                if (arm_to_fpga_data_valid && ready_r) begin
                    rx_load_s = 1'b1;
                    state_s   = ST_DONE;
                end else begin
                    state_s = ST_RX;
                end
            end
            ST_COMPUTE: begin
                // start_r is high only in the launch cycle, where core_done is stale
                if (core_done && !start_r) begin
                    res_load_s = 1'b1;
                    state_s    = ST_DONE;
                end else begin
`ifdef CMD_TIMEOUT_EN
                    if (wdog_r == TIMEOUT_LAST) begin
                        err_set_s = 1'b1;
                        state_s   = ST_DONE;
                    end else begin
                        state_s = ST_COMPUTE;
                    end
`else
                    state_s = ST_COMPUTE;
`endif
                end
            end
            ST_TX: begin
                if (valid_r && fpga_to_arm_data_ready) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_TX;
                end
            end
            ST_DONE: begin
                if (fpga_to_arm_done_read) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register and registered handshake outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
            code_r  <= 3'd0;
            err_r   <= 1'b0;
            ready_r <= 1'b0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
            start_r <= 1'b0;
            mode_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ready_r <= (state_s == ST_RX);
            valid_r <= (state_s == ST_TX);
            done_r  <= (state_s == ST_DONE);
            start_r <= start_s;
            if (latch_s) begin
                code_r <= arm_to_fpga_cmd[2:0];
            end
            if (start_s) begin
                mode_r <= arm_to_fpga_cmd[0];
            end
            if (err_set_s) begin
                err_r <= 1'b1;
            end else if (err_clr_s) begin
                err_r <= 1'b0;
            end
        end
    end

    // Operand and result holding registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mod_q <= '0;
            rsq_q <= '0;
            exp_q <= '0;
            res_r <= '0;
        end else begin
            if (rx_load_s) begin
                case (code_r)
                    3'd2:    mod_q <= arm_to_fpga_data;
                    3'd3:    rsq_q <= arm_to_fpga_data;
                    3'd4:    exp_q <= arm_to_fpga_data;
                    default: mod_q <= mod_q;
                endcase
            end
            if (res_load_s) begin
                res_r <= core_result;
            end
        end
    end

`ifdef CMD_TIMEOUT_EN
    // Watchdog: cleared on entry to COMPUTE, counts every COMPUTE cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wdog_r <= 32'd0;
        end else if (start_s) begin
            wdog_r <= 32'd0;
        end else if (state_r == ST_COMPUTE) begin
            wdog_r <= wdog_r + 32'd1;
        end else begin
            wdog_r <= wdog_r;
        end
    end
`endif

    assign fpga_to_arm_done       = done_r;
    assign arm_to_fpga_data_ready = ready_r;
    assign fpga_to_arm_data_valid = valid_r;
    assign fpga_to_arm_data       = {{(DATA_W-RES_W){1'b0}}, res_r};
    assign core_start             = start_r;
    assign core_mode              = mode_r;
    assign leds                   = {err_r, state_r};

endmodule

// File: tb/tb_rsa_cmd_responder.sv
// Directed, table-driven bench for rsa_cmd_responder.
module tb_rsa_cmd_responder;

    localparam int DW = 1024;
    localparam int RW = 512;
`ifdef CMD_TIMEOUT_EN
    localparam int TB_TIMEOUT = 16;
`else
    localparam int TB_TIMEOUT = 65536;
`endif

    localparam logic [DW-1:0] OP_A  = {{16{32'hda8f5c92}}, {16{32'hdebcfd28}}};
    localparam logic [DW-1:0] OP_A2 = {32{32'h13572468}};
    localparam logic [DW-1:0] OP_M  = {32{32'h8dc4379c}};
    localparam logic [DW-1:0] OP_E  = {32{32'h00010001}};
    localparam logic [DW-1:0] OP_E2 = {32{32'hcafe0003}};
    localparam logic [RW-1:0] RES_R = {{15{32'h1ad69dee}}, 32'h00041f33};
    localparam logic [RW-1:0] RES_X = {16{32'hdeadbeef}};

    logic          clk = 1'b0;
    logic          resetn;
    logic [31:0]   cmd;
    logic          cmd_valid;
    logic          done;
    logic          done_read;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          core_start;
    logic          core_mode;
    logic          core_done;
    logic [RW-1:0] core_result;
    logic [DW-1:0] mod_q, rsq_q, exp_q;
    logic [3:0]    leds;

    int n_cmp = 0;
    int n_bad = 0;
    int start_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (core_start) start_cnt <= start_cnt + 1;
    end

    rsa_cmd_responder #(.DATA_W(DW), .RES_W(RW), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk(clk), .resetn(resetn),
        .arm_to_fpga_cmd(cmd), .arm_to_fpga_cmd_valid(cmd_valid),
        .fpga_to_arm_done(done), .fpga_to_arm_done_read(done_read),
        .arm_to_fpga_data_valid(in_valid), .arm_to_fpga_data_ready(in_ready),
        .arm_to_fpga_data(in_data),
        .fpga_to_arm_data_valid(out_valid), .fpga_to_arm_data_ready(out_ready),
        .fpga_to_arm_data(out_data),
        .core_start(core_start), .core_mode(core_mode),
        .core_done(core_done), .core_result(core_result),
        .mod_q(mod_q), .rsq_q(rsq_q), .exp_q(exp_q), .leds(leds)
    );

    typedef struct {
        logic [31:0]   cmd;
        logic [DW-1:0] data;
        logic [3:0]    exp_leds;
        logic          exp_ready;
        logic          exp_valid;
        logic          exp_err_after;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_cmd(input logic [31:0] c);
        cmd       = c;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cmd       = 32'd0;
    endtask

    task automatic finish_done(input string name);
        chk({name, "_done_hi"}, {1023'd0, done}, 1024'd1);
        done_read = 1'b1;
        tick();
        done_read = 1'b0;
        chk({name, "_done_lo"}, {1023'd0, done}, 1024'd0);
        chk({name, "_idle"}, {1021'd0, leds[2:0]}, 1024'd0);
    endtask

    initial begin
        resetn = 1'b0; cmd = 32'd0; cmd_valid = 1'b0; done_read = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        core_done = 1'b0; core_result = '0;

        vecs[0] = '{cmd: 32'd2,     data: OP_M,  exp_leds: 4'b0001, exp_ready: 1'b1, exp_valid: 1'b0, exp_err_after: 1'b0};
        vecs[1] = '{cmd: 32'd4,     data: OP_E,  exp_leds: 4'b0001, exp_ready: 1'b1, exp_valid: 1'b0, exp_err_after: 1'b0};
        vecs[2] = '{cmd: 32'd5,     data: '0,    exp_leds: 4'b0011, exp_ready: 1'b0, exp_valid: 1'b1, exp_err_after: 1'b0};
        vecs[3] = '{cmd: 32'd7,     data: '0,    exp_leds: 4'b1100, exp_ready: 1'b0, exp_valid: 1'b0, exp_err_after: 1'b1};
        vecs[4] = '{cmd: 32'h100,   data: '0,    exp_leds: 4'b1100, exp_ready: 1'b0, exp_valid: 1'b0, exp_err_after: 1'b1};
        vecs[5] = '{cmd: 32'd3,     data: OP_A2, exp_leds: 4'b0001, exp_ready: 1'b1, exp_valid: 1'b0, exp_err_after: 1'b0};

        // reset state
        tick();
        tick();
        chk("rst_leds", {1020'd0, leds}, 1024'd0);
        chk("rst_done", {1023'd0, done}, 1024'd0);
        chk("rst_ready", {1023'd0, in_ready}, 1024'd0);
        chk("rst_valid", {1023'd0, out_valid}, 1024'd0);
        chk("rst_start", {1023'd0, core_start}, 1024'd0);
        chk("rst_data", out_data, 1024'd0);
        chk("rst_mod", mod_q, 1024'd0);
        resetn = 1'b1;
        tick();

        // test 1: READ_RSQ with held done
        send_cmd(32'd3);
        chk("t1_leds_rx", {1020'd0, leds}, 1024'd1);
        chk("t1_ready", {1023'd0, in_ready}, 1024'd1);
        in_data = OP_A; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t1_ready_drop", {1023'd0, in_ready}, 1024'd0);
        chk("t1_rsq", rsq_q, OP_A);
        chk("t1_leds_done", {1020'd0, leds}, 1024'd4);
        tick();
        chk("t1_done_held", {1023'd0, done}, 1024'd1);
        finish_done("t1");

        // table: command decode and completion
        for (int i = 0; i < 6; i++) begin
            send_cmd(vecs[i].cmd);
            chk($sformatf("v%0d_leds", i), {1020'd0, leds}, {1020'd0, vecs[i].exp_leds});
            chk($sformatf("v%0d_ready", i), {1023'd0, in_ready}, {1023'd0, vecs[i].exp_ready});
            chk($sformatf("v%0d_valid", i), {1023'd0, out_valid}, {1023'd0, vecs[i].exp_valid});
            chk($sformatf("v%0d_start", i), {1023'd0, core_start}, 1024'd0);
            if (vecs[i].exp_ready) begin
                in_data = vecs[i].data; in_valid = 1'b1;
                tick();
                in_valid = 1'b0;
            end else if (vecs[i].exp_valid) begin
                chk($sformatf("v%0d_wr_zero", i), out_data, 1024'd0);
                out_ready = 1'b1;
                tick();
                out_ready = 1'b0;
            end
            case (vecs[i].cmd)
                32'd2:   chk($sformatf("v%0d_mod", i), mod_q, vecs[i].data);
                32'd3:   chk($sformatf("v%0d_rsq", i), rsq_q, vecs[i].data);
                32'd4:   chk($sformatf("v%0d_exp", i), exp_q, vecs[i].data);
                default: ;
            endcase
            finish_done($sformatf("v%0d", i));
            chk($sformatf("v%0d_err", i), {1023'd0, leds[3]}, {1023'd0, vecs[i].exp_err_after});
        end

        // test 2 + 5: COMPUTE_MONT, stale core_done and cmd_valid ignored
        send_cmd(32'd1);
        chk("t2_start", {1023'd0, core_start}, 1024'd1);
        chk("t2_mode", {1023'd0, core_mode}, 1024'd1);
        chk("t2_leds", {1020'd0, leds}, 1024'd2);
        core_done = 1'b1; core_result = RES_X;
        tick();
        core_done = 1'b0;
        chk("t2_start_pulse", {1023'd0, core_start}, 1024'd0);
        chk("t2_stale_done", {1020'd0, leds}, 1024'd2);
        cmd = 32'd3; cmd_valid = 1'b1; in_valid = 1'b1; in_data = OP_A;
        tick();
        cmd_valid = 1'b0; in_valid = 1'b0;
        chk("t5_cmd_in_compute", {1020'd0, leds}, 1024'd2);
        chk("t5_rsq_kept", rsq_q, OP_A2);
        repeat (36) tick();
        core_done = 1'b1; core_result = RES_R;
        tick();
        core_done = 1'b0;
        chk("t2_done_latency", {1023'd0, done}, 1024'd1);
        chk("t2_res", out_data, {512'd0, RES_R});
        chk("t2_start_count", 1024'(start_cnt), 1024'd1);
        finish_done("t2");

        // test 3: WRITE with ready held low
        send_cmd(32'd5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t3_valid_%0d", k), {1023'd0, out_valid}, 1024'd1);
            chk($sformatf("t3_data_%0d", k), out_data, {512'd0, RES_R});
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t3_valid_drop", {1023'd0, out_valid}, 1024'd0);
        finish_done("t3");

        // test 5: cmd_valid during RX ignored
        send_cmd(32'd4);
        cmd = 32'd2; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("t5_rx_state", {1020'd0, leds}, 1024'd1);
        in_data = OP_E2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t5_exp", exp_q, OP_E2);
        chk("t5_mod_kept", mod_q, OP_M);
        finish_done("t5");

        // test 6: reset during COMPUTE, then a late core_done
        send_cmd(32'd0);
        chk("t6_mode", {1023'd0, core_mode}, 1024'd0);
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        core_done = 1'b1; core_result = RES_X;
        tick();
        core_done = 1'b0;
        chk("t6_leds", {1020'd0, leds}, 1024'd0);
        chk("t6_done", {1023'd0, done}, 1024'd0);
        chk("t6_res", out_data, 1024'd0);
        chk("t6_mod", mod_q, 1024'd0);

        // watchdog behaviour (or its absence)
        send_cmd(32'd0);
        repeat (15) tick();
        chk("wd_still_compute", {1020'd0, leds}, 1024'd2);
        tick();
`ifdef CMD_TIMEOUT_EN
        chk("wd_abort", {1020'd0, leds}, 1024'd12);
        core_done = 1'b1; core_result = RES_X;
        tick();
        core_done = 1'b0;
        chk("wd_res_kept", out_data, 1024'd0);
        finish_done("wd");
`else
        repeat (10) tick();
        chk("wd_no_abort", {1020'd0, leds}, 1024'd2);
        core_done = 1'b1; core_result = RES_R;
        tick();
        core_done = 1'b0;
        chk("wd_res", out_data, {512'd0, RES_R});
        finish_done("wd");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
